// File: rtl/sprite_motion_ctl_pkg.sv
// Shared constants and types for the sprite motion controller: screen size,
// position width, FSM state codes and the direction encoding.
package sprite_motion_ctl_pkg;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;
  localparam int POS_W    = 12;
  localparam int COLL_W   = 8;

  localparam logic [1:0] ST_WAIT_FRAME = 2'd0;
  localparam logic [1:0] ST_CALC       = 2'd1;
  localparam logic [1:0] ST_COMMIT     = 2'd2;

  localparam logic DIR_INC = 1'b0;  // right / down
  localparam logic DIR_DEC = 1'b1;  // left / up

  // Result of the CALC stage, held until COMMIT copies it to the outputs.
  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             dir_x;
    logic             dir_y;
    logic             bounce;
  } motion_t;

endpackage

// File: rtl/sprite_motion_ctl_axis.sv
// Single-axis step/clamp/flip: advances a position by STEP toward 0 or LIMIT,
// clamping onto the limit and reversing direction when it is reached.
module sprite_motion_ctl_axis
  import sprite_motion_ctl_pkg::*;
#(
  parameter int STEP  = 2,
  parameter int LIMIT = 736
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  output logic [POS_W-1:0] pos_nxt,
  output logic             dir_nxt,
  output logic             bounce
);

  localparam logic [POS_W:0]   LIMIT_W = (POS_W+1)'(LIMIT);
  localparam logic [POS_W-1:0] STEP_W  = POS_W'(STEP);

  // One extra bit so a start position above the limit cannot wrap past it.
  logic [POS_W:0] sum;
  assign sum = {1'b0, pos} + {1'b0, STEP_W};

  // NOTE: every output gets a default first, so no path through this block
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    bounce  = 1'b0;
    if (dir == DIR_INC) begin
      if (sum >= LIMIT_W) begin
        pos_nxt = LIMIT_W[POS_W-1:0];
        dir_nxt = DIR_DEC;
        bounce  = 1'b1;
      end else begin
        pos_nxt = sum[POS_W-1:0];
      end
    end else if (pos <= STEP_W) begin
      pos_nxt = '0;
      dir_nxt = DIR_INC;
      bounce  = 1'b1;
    end else begin
      pos_nxt = pos - STEP_W;
    end
  end

endmodule

// File: rtl/sprite_motion_ctl.sv
// Per-frame sprite position generator with edge bounce and collision hold.
// Define SPRITE_MOTION_GRAVITY_EN for an accelerating, floor-bouncing y axis.
module sprite_motion_ctl
  import sprite_motion_ctl_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int HEIGHT      = 64,
  parameter int MAX_X       = SCREEN_W,
  parameter int MAX_Y       = SCREEN_H,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0,
  parameter int STEP_X      = 2,
  parameter int STEP_Y      = 2,
  parameter int COLL_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vblnk_in,
  input  logic             enable,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             colission,
  output logic [15:0]      frame_cnt
);

  localparam int XL = MAX_X - WIDTH;
  localparam int YL = MAX_Y - HEIGHT;

  logic [1:0]        state_q, state_d;
  logic              vblnk_prev_q;
  logic [POS_W-1:0]  x_q, x_d, y_q, y_d;
  logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [COLL_W-1:0] coll_cnt_q, coll_cnt_d;
  logic              colission_q, colission_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  motion_t           calc_q, calc_d;
  logic              tick;

  logic [POS_W-1:0]  x_step, y_step;
  logic              dir_x_step, dir_y_step, bounce_x, bounce_y;

  assign tick = vblnk_in & ~vblnk_prev_q;

  sprite_motion_ctl_axis #(.STEP(STEP_X), .LIMIT(XL)) u_axis_x (
    .pos     (x_q),
    .dir     (dir_x_q),
    .pos_nxt (x_step),
    .dir_nxt (dir_x_step),
    .bounce  (bounce_x)
  );

`ifdef SPRITE_MOTION_GRAVITY_EN
  logic signed [7:0]  vy_q, vy_d, vy_calc_q, vy_calc_d, vy_inc;
  logic signed [13:0] y_sum;

  always_comb begin
    vy_inc     = (vy_q >= 8'sd15) ? 8'sd15 : vy_q + 8'sd1;
    y_sum      = $signed({2'b00, y_q}) + 14'(vy_inc);
    y_step     = y_sum[POS_W-1:0];
    vy_calc_d  = vy_inc;
    bounce_y   = 1'b0;
    dir_y_step = dir_y_q;
    if (y_sum >= 14'sd0 + 14'(YL)) begin
      y_step    = POS_W'(YL);
      vy_calc_d = -vy_inc;
      bounce_y  = 1'b1;
    end else if (vy_inc < 8'sd0 && y_sum <= 14'sd0) begin
      y_step    = '0;
      vy_calc_d = 8'sd0;
      bounce_y  = 1'b1;
    end
  end
`else
  sprite_motion_ctl_axis #(.STEP(STEP_Y), .LIMIT(YL)) u_axis_y (
    .pos     (y_q),
    .dir     (dir_y_q),
    .pos_nxt (y_step),
    .dir_nxt (dir_y_step),
    .bounce  (bounce_y)
  );
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    coll_cnt_d  = coll_cnt_q;
    frame_cnt_d = frame_cnt_q;
    calc_d      = calc_q;
    case (state_q)
      ST_WAIT_FRAME: if (tick && enable) state_d = ST_CALC;
      ST_CALC: begin
        calc_d = '{x: x_step, y: y_step, dir_x: dir_x_step, dir_y: dir_y_step,
                   bounce: bounce_x | bounce_y};
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        x_d         = calc_q.x;
        y_d         = calc_q.y;
        dir_x_d     = calc_q.dir_x;
        dir_y_d     = calc_q.dir_y;
        frame_cnt_d = frame_cnt_q + 16'd1;
        // A bounce reloads the hold time even if one is already running.
        if (calc_q.bounce)          coll_cnt_d = COLL_W'(COLL_FRAMES);
        else if (coll_cnt_q != '0)  coll_cnt_d = coll_cnt_q - 1'b1;
        state_d = ST_WAIT_FRAME;
      end
      default: state_d = ST_WAIT_FRAME;
    endcase
    colission_d = (coll_cnt_d != '0);
  end

`ifdef SPRITE_MOTION_GRAVITY_EN
  always_comb begin
    vy_d = vy_q;
    if (state_q == ST_COMMIT) vy_d = vy_calc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vy_q      <= 8'sd0;
      vy_calc_q <= 8'sd0;
    end else begin
      vy_q      <= vy_d;
      if (state_q == ST_CALC) vy_calc_q <= vy_calc_d;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge regardless of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_FRAME;
      vblnk_prev_q <= 1'b0;
      x_q          <= POS_W'(X_INIT);
      y_q          <= POS_W'(Y_INIT);
      dir_x_q      <= DIR_INC;
      dir_y_q      <= DIR_INC;
      coll_cnt_q   <= '0;
      colission_q  <= 1'b0;
      frame_cnt_q  <= '0;
      calc_q       <= '0;
    end else begin
      state_q      <= state_d;
      vblnk_prev_q <= vblnk_in;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      coll_cnt_q   <= coll_cnt_d;
      colission_q  <= colission_d;
      frame_cnt_q  <= frame_cnt_d;
      calc_q       <= calc_d;
    end
  end

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign colission = colission_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sprite_motion_ctl.sv
// Randomized frame stimulus against a behavioural bounce model; a monitor
// pops expected frames from a queue whenever the DUT frame counter advances.
module tb_sprite_motion_ctl;

  localparam int X0 = 100;
  localparam int Y0 = 50;
  localparam int XL = 800 - 64;
  localparam int YL = 600 - 64;
  localparam int STEP = 2;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk_in = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] x_pos, y_pos;
  logic        colission;
  logic [15:0] frame_cnt;

  sprite_motion_ctl #(.X_INIT(X0), .Y_INIT(Y0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk_in  (vblnk_in),
    .enable    (enable),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .colission (colission),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int col; int fc; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int mx, my, mfc, mhold;
  bit mleft, mup;

  bit mon_en = 1'b0;
  int last_x, last_y, last_col, last_fc;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = X0; my = Y0; mfc = 0; mhold = 0; mleft = 0; mup = 0;
    last_x = X0; last_y = Y0; last_col = 0; last_fc = 0;
    exp_q.delete();
  endtask

  // One axis moved by the bounce rules; returns 1 on an edge hit.
  function automatic bit move(inout int p, inout bit back, input int lim);
    if (!back) begin
      if (p + STEP >= lim) begin p = lim; back = 1; return 1; end
      p = p + STEP;
    end else begin
      if (p <= STEP) begin p = 0; back = 0; return 1; end
      p = p - STEP;
    end
    return 0;
  endfunction

  task automatic model_tick();
    bit hx, hy;
    exp_t e;
    hx = move(mx, mleft, XL);
    hy = move(my, mup, YL);
    if (hx || hy) mhold = HOLD;
    else if (mhold > 0) mhold--;
    mfc = (mfc + 1) % 65536;
    e.x = mx; e.y = my; e.col = (mhold > 0); e.fc = mfc;
    exp_q.push_back(e);
  endtask

  // One vblank pulse: rise, hold high, fall, stay low.
  task automatic frame(input bit en, input bit drop, input int hi, input int lo);
    @(negedge clk);
    enable = en;
    vblnk_in = 1'b1;
    if (en) model_tick();
    if (drop) begin
      @(negedge clk);
      enable = 1'b0;
      hi--;
    end
    repeat (hi) @(negedge clk);
    vblnk_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (int'(frame_cnt) != last_fc) begin
          if (exp_q.size() == 0) begin
            check("unexpected_update", int'(frame_cnt), last_fc);
          end else begin
            e = exp_q.pop_front();
            check("x_pos", int'(x_pos), e.x);
            check("y_pos", int'(y_pos), e.y);
            check("colission", int'(colission), e.col);
            check("frame_cnt", int'(frame_cnt), e.fc);
          end
        end else if (int'(x_pos) != last_x || int'(y_pos) != last_y ||
                     int'(colission) != last_col) begin
          check("hold_x", int'(x_pos), last_x);
          check("hold_y", int'(y_pos), last_y);
          check("hold_col", int'(colission), last_col);
        end
        last_x = int'(x_pos); last_y = int'(y_pos);
        last_col = int'(colission); last_fc = int'(frame_cnt);
      end
    end
  end

  initial begin : stimulus
    model_reset();
    // Reset with vblank already high and motion off.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_x", int'(x_pos), X0);
    check("rst_y", int'(y_pos), Y0);
    check("rst_col", int'(colission), 0);
    check("rst_fc", int'(frame_cnt), 0);
    mon_en = 1'b1;

    // Enabling while vblank stays high must not produce a tick.
    enable = 1'b1;
    repeat (5) @(negedge clk);
    check("no_tick_held_high", int'(frame_cnt), 0);
    vblnk_in = 1'b0;
    repeat (4) @(negedge clk);

    // Latency: rise sampled at edge T, outputs move after edge T+2.
    @(negedge clk);
    vblnk_in = 1'b1;
    model_tick();
    @(negedge clk);
    check("lat_t0_x", int'(x_pos), X0);
    @(negedge clk);
    check("lat_t1_x", int'(x_pos), X0);
    check("lat_t1_y", int'(y_pos), Y0);
    @(negedge clk);
    check("lat_t2_x", int'(x_pos), X0 + STEP);
    check("lat_t2_y", int'(y_pos), Y0 + STEP);
    repeat (997) @(negedge clk);
    check("one_tick_long_high", int'(frame_cnt), 1);
    vblnk_in = 1'b0;
    repeat (4) @(negedge clk);

    // Freeze over five ticks.
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b0, 4, 4);
    check("freeze_x", int'(x_pos), mx);
    check("freeze_y", int'(y_pos), my);
    check("freeze_col", int'(colission), int'(mhold > 0));
    check("freeze_fc", int'(frame_cnt), mfc);

    // Long random run: covers right, bottom, top and left bounces and retriggers.
    for (int i = 0; i < 900; i++) begin
      bit en;
      bit drop;
      en   = ($urandom_range(0, 99) < 85);
      drop = en && ($urandom_range(0, 9) == 0);
      frame(en, drop, $urandom_range(3, 8), $urandom_range(3, 8));
    end
    drain();
    check("final_x", int'(x_pos), mx);
    check("final_fc", int'(frame_cnt), mfc);

    // Reset arriving while a tick is in CALC discards it.
    mon_en = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    vblnk_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_x", int'(x_pos), X0);
    check("midrst_y", int'(y_pos), Y0);
    check("midrst_col", int'(colission), 0);
    repeat (4) @(negedge clk);
    check("midrst_fc", int'(frame_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
